rf_wb_ctrl: RTL



---
 rtl/rf_ctrl_pkg.sv | 10 +
 rtl/rr_arbiter.sv | 41 ++++
 rtl/rf_wb_ctrl.sv | 116 +++++++++++
 3 files changed

// File: rtl/rf_ctrl_pkg.sv
// Shared types and sizes for the register-file write-back controller.
package rf_ctrl_pkg;

  localparam int NREG = 32;
  localparam int XLEN = 32;

  typedef logic [4:0]      reg_idx_t;
  typedef logic [XLEN-1:0] xlen_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the
// priority pointer; the pointer moves past the winner on every grant.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic          found;
  int            idx;

  // Search from the pointer, wrapping, and pick the first active request.
  always_comb begin
    gnt_o = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = 0;
    for (int off = 0; off < N; off++) begin
      idx = int'(ptr_q) + off;
      if (idx >= N) idx = idx - N;
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
        ptr_d      = (idx == N - 1) ? '0 : PW'(idx + 1);
      end
    end
  end

  // Priority pointer register.
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/rf_wb_ctrl.sv
// Write-back controller: arbitrates NREQ write-back sources onto the single
// register-file write port through one register stage and tracks pending
// destination registers for decode RAW/WAW checks.
// Optional feature macro: RF_WB_FWD_EN adds rs1_fwd/rs2_fwd/fwd_data bypass
// outputs and clears rsN_busy during the cycle the matching write is on the port.
module rf_wb_ctrl
  import rf_ctrl_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int XLEN = rf_ctrl_pkg::XLEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*5-1:0] req_rd,
  input  logic [NREQ*XLEN-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  input  logic              iss_valid,
  input  logic [4:0]        iss_rd,
  output logic              iss_ready,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  output logic              rs1_busy,
  output logic              rs2_busy,
`ifdef RF_WB_FWD_EN
  output logic              rs1_fwd,
  output logic              rs2_fwd,
  output logic [XLEN-1:0]   fwd_data,
`endif
  output logic              rf_we,
  output logic [4:0]        rf_rd,
  output logic [XLEN-1:0]   rf_wdata
);

  logic [NREQ-1:0] gnt;
  reg_idx_t        sel_rd;
  logic [XLEN-1:0] sel_data;

  logic            rf_we_q, rf_we_d;
  reg_idx_t        rf_rd_q, rf_rd_d;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
  logic [NREG-1:0] busy_q, busy_d;

  // Requests are masked during reset so no grant escapes.
  rr_arbiter #(.N(NREQ)) u_arb (
    .clk   (clk),
    .rst   (rst),
    .req_i (req_valid & {NREQ{~rst}}),
    .gnt_o (gnt)
  );

  assign req_ready = gnt;

  // Select the granted requester's destination and data.
  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_rd   = req_rd[5*i +: 5];
        sel_data = req_data[XLEN*i +: XLEN];
      end
    end
  end

  // Write-port next state: x0 grants take the slot but never assert the write.
  always_comb begin
    rf_we_d    = (|gnt) && (sel_rd != 5'd0);
    rf_rd_d    = (|gnt) ? sel_rd   : rf_rd_q;
    rf_wdata_d = (|gnt) ? sel_data : rf_wdata_q;
  end

  // A reservation can only be taken on a register that is not already pending,
  // including one whose clearing write is on the port this cycle.
  assign iss_ready = (iss_rd == 5'd0) || !busy_q[iss_rd];

  // Scoreboard update: clear on write, then set, so a same-cycle set wins.
  always_comb begin
    busy_d = busy_q;
    if (rf_we_q) busy_d[rf_rd_q] = 1'b0;
    if (iss_valid && iss_ready && (iss_rd != 5'd0)) busy_d[iss_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Registered write stage and scoreboard.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we_q    <= 1'b0;
      rf_rd_q    <= '0;
      rf_wdata_q <= '0;
      busy_q     <= '0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_rd_q    <= rf_rd_d;
      rf_wdata_q <= rf_wdata_d;
      busy_q     <= busy_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_rd    = rf_rd_q;
  assign rf_wdata = rf_wdata_q;

`ifdef RF_WB_FWD_EN
  // The value being written this cycle can be bypassed to decode.
  assign rs1_fwd  = rf_we_q && (rf_rd_q == rs1) && (rs1 != 5'd0);
  assign rs2_fwd  = rf_we_q && (rf_rd_q == rs2) && (rs2 != 5'd0);
  assign fwd_data = rf_wdata_q;
  assign rs1_busy = busy_q[rs1] && !rs1_fwd;
  assign rs2_busy = busy_q[rs2] && !rs2_fwd;
`else
  assign rs1_busy = busy_q[rs1];
  assign rs2_busy = busy_q[rs2];
`endif

endmodule
